// File: rtl/rshp_pkg.sv
// Shared types and default sizing for the FIFO-to-beat packer.
package rshp_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_PK = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/rshp_packer.sv
// Packs PK consecutive upstream FIFO words into one wide output beat, with a flush
// sequence that emits any partially filled beat with a lane-valid mask.
module rshp_packer
    import rshp_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned PK = DEF_PK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ffrempty,
    output logic             ffrreq,
    input  logic [DW-1:0]    ffrdata,
    input  logic             ffrvld,
    input  logic             flush,
    output logic [PK*DW-1:0] odata,
    output logic [PK-1:0]    okeep,
    output logic             ovld,
    input  logic             ordy,
    output logic             flush_done
);

    localparam int unsigned CW = $clog2(PK) + 1;
    localparam logic [CW-1:0] FULL = CW'(PK);
    localparam logic [CW:0] FULL_OCC = (CW + 1)'(PK);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             inflight;
    logic [PK*DW-1:0] lanes;

    logic             oready;
    logic [CW:0]      occ;
    logic [CW-1:0]    cnt_wr;
    logic [PK*DW-1:0] lanes_wr;
    logic [PK-1:0]    part_keep;

    assign oready = ~ovld | ordy;
    assign occ    = {1'b0, cnt} + {{CW{1'b0}}, inflight};

    // A request at occ == PK is only safe when the in-flight word completes the
    // beat on an edge where the output register can take it.
    always_comb begin
        ffrreq = 1'b0;
        if (!reset && state == RUN && !ffrempty) begin
            if (occ < FULL_OCC) begin
                ffrreq = 1'b1;
            end else if (occ == FULL_OCC && inflight && oready) begin
                ffrreq = 1'b1;
            end
        end
    end

    always_comb begin
        lanes_wr = lanes;
        cnt_wr   = cnt;
        if (ffrvld && cnt < FULL) begin
            lanes_wr[cnt*DW +: DW] = ffrdata;
            cnt_wr                 = cnt + CW'(1);
        end
    end

    always_comb begin
        part_keep = '0;
        for (int i = 0; i < int'(PK); i++) begin
            part_keep[i] = (CW'(i) < cnt);
        end
    end

    // Lanes are cleared whenever a beat leaves, so lanes above cnt are always zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            cnt        <= '0;
            inflight   <= 1'b0;
            lanes      <= '0;
            odata      <= '0;
            okeep      <= '0;
            ovld       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            inflight   <= ffrreq;
            flush_done <= 1'b0;
            cnt        <= cnt_wr;
            lanes      <= lanes_wr;

            if (ovld && ordy) begin
                ovld <= 1'b0;
            end

            // Covers both a beat completing this edge and one already held at cnt == PK.
            if (cnt_wr == FULL && oready) begin
                odata <= lanes_wr;
                okeep <= '1;
                ovld  <= 1'b1;
                cnt   <= '0;
                lanes <= '0;
            end

            case (state)
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight && cnt != FULL) begin
                        if (cnt != '0) begin
                            state <= EMIT;
                        end else begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (oready) begin
                        odata      <= lanes;
                        okeep      <= part_keep;
                        ovld       <= 1'b1;
                        cnt        <= '0;
                        lanes      <= '0;
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rshp_packer.sv
// Scoreboard bench for rshp_packer (DW=8, PK=4) driven by a simple upstream FIFO model.
module tb_rshp_packer;

    localparam int DW = 8;
    localparam int PK = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ffrempty;
    logic             ffrreq;
    logic [DW-1:0]    ffrdata = '0;
    logic             ffrvld = 1'b0;
    logic             flush = 1'b0;
    logic [PK*DW-1:0] odata;
    logic [PK-1:0]    okeep;
    logic             ovld;
    logic             ordy = 1'b0;
    logic             flush_done;

    logic [DW-1:0]    mem [0:255];
    int unsigned      wr_ptr = 0;
    int unsigned      rd_ptr = 0;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int fd_count = 0;
    int fd_cyc = -1;

    logic [PK*DW-1:0] exp_data [$];
    logic [PK-1:0]    exp_keep [$];

    logic             hold_v = 1'b0;
    logic [PK*DW-1:0] hold_d;
    logic [PK-1:0]    hold_k;
    logic             fd_prev = 1'b0;

    rshp_packer #(.DW(DW), .PK(PK)) dut (
        .clk       (clk),
        .reset     (reset),
        .ffrempty  (ffrempty),
        .ffrreq    (ffrreq),
        .ffrdata   (ffrdata),
        .ffrvld    (ffrvld),
        .flush     (flush),
        .odata     (odata),
        .okeep     (okeep),
        .ovld      (ovld),
        .ordy      (ordy),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO: data valid one cycle after a request; reset discards contents.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ffrvld  <= 1'b0;
            ffrdata <= '0;
            rd_ptr  <= wr_ptr;
        end else begin
            ffrvld <= ffrreq;
            if (ffrreq) begin
                ffrdata <= mem[rd_ptr[7:0]];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end
    assign ffrempty = (rd_ptr == wr_ptr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: handshake scoreboard, hold-stability and flush_done tracking.
    always @(negedge clk) begin
        if (reset) begin
            hold_v  = 1'b0;
            fd_prev = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_ovld", 64'(ovld), 64'd1);
                check("hold_odata", 64'(odata), 64'(hold_d));
                check("hold_okeep", 64'(okeep), 64'(hold_k));
            end
            if (flush_done) begin
                if (fd_prev) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL flush_done_width: high for more than one cycle at cycle %0d", cyc);
                end
                fd_count++;
                fd_cyc = cyc;
            end
            fd_prev = flush_done;
            if (ovld && ordy) begin
                if (exp_data.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got odata=%h okeep=%b expected no beat",
                             odata, okeep);
                end else begin
                    check("beat_odata", 64'(odata), 64'(exp_data.pop_front()));
                    check("beat_okeep", 64'(okeep), 64'(exp_keep.pop_front()));
                end
            end
            hold_v = ovld && !ordy;
            hold_d = odata;
            hold_k = okeep;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask

    task automatic expect_beat(input logic [PK*DW-1:0] d, input logic [PK-1:0] k);
        exp_data.push_back(d);
        exp_keep.push_back(k);
    endtask

    task automatic drain_wait(input string name);
        int t = 0;
        while (exp_data.size() != 0 && t < 100) begin
            tick(1);
            t++;
        end
        check(name, 64'(exp_data.size()), 64'd0);
        tick(1);
    endtask

    task automatic count_req(input int ncyc, output int total, output int max_run);
        int run = 0;
        total   = 0;
        max_run = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (ffrreq) begin
                total++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(output int fc);
        flush = 1'b1;
        fc    = cyc;
        tick(1);
        flush = 1'b0;
    endtask

    initial begin
        int total, max_run, fc, fd0;

        #2;
        check("rst_ovld", 64'(ovld), 64'd0);
        check("rst_odata", 64'(odata), 64'd0);
        check("rst_okeep", 64'(okeep), 64'd0);
        check("rst_ffrreq", 64'(ffrreq), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);

        // Streaming with downstream always ready.
        ordy = 1'b1;
        expect_beat(32'h04030201, 4'hF);
        expect_beat(32'h08070605, 4'hF);
        for (int i = 1; i <= 8; i++) push(8'(i));
        count_req(12, total, max_run);
        check("stream_req_total", 64'(total), 64'd8);
        check("stream_req_run", 64'(max_run), 64'd8);
        drain_wait("stream_drain");

        // Backpressure: second beat held at cnt=PK, reads stop.
        ordy = 1'b0;
        expect_beat(32'h14131211, 4'hF);
        expect_beat(32'h18171615, 4'hF);
        for (int i = 1; i <= 8; i++) push(8'(8'h10 + i));
        count_req(10, total, max_run);
        check("bp_req_total", 64'(total), 64'd8);
        check("bp_ovld", 64'(ovld), 64'd1);
        check("bp_ffrreq_idle", 64'(ffrreq), 64'd0);
        check("bp_fifo_empty", 64'(ffrempty), 64'd1);
        ordy = 1'b1;
        drain_wait("bp_drain");

        // Partial beat via flush.
        expect_beat(32'h00A3A2A1, 4'b0111);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        tick(6);
        fd0 = fd_count;
        do_flush(fc);
        tick(6);
        check("partial_fd_delay", 64'(fd_cyc - fc), 64'd3);
        check("partial_fd_count", 64'(fd_count - fd0), 64'd1);
        drain_wait("partial_drain");

        // Flush with nothing buffered: no beat, DRAIN then DONE.
        fd0 = fd_count;
        do_flush(fc);
        tick(5);
        check("empty_fd_delay", 64'(fd_cyc - fc), 64'd2);
        check("empty_fd_count", 64'(fd_count - fd0), 64'd1);
        check("empty_no_beat", 64'(ovld), 64'd0);

        // Flush coincident with the request for the second word.
        expect_beat(32'h0000B2B1, 4'b0011);
        push(8'hB1);
        push(8'hB2);
        tick(1);
        check("coinc_req", 64'(ffrreq), 64'd1);
        fd0 = fd_count;
        do_flush(fc);
        tick(6);
        check("coinc_fd_delay", 64'(fd_cyc - fc), 64'd4);
        check("coinc_fd_count", 64'(fd_count - fd0), 64'd1);
        drain_wait("coinc_drain");

        // Reset mid-operation with a held beat and two buffered lanes.
        ordy = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(8'hC0 + i));
        tick(8);
        push(8'hD1);
        push(8'hD2);
        tick(6);
        check("prerst_ovld", 64'(ovld), 64'd1);
        check("prerst_odata", 64'(odata), 64'hC4C3C2C1);
        reset = 1'b1;
        #1;
        check("midrst_ovld", 64'(ovld), 64'd0);
        check("midrst_odata", 64'(odata), 64'd0);
        check("midrst_okeep", 64'(okeep), 64'd0);
        check("midrst_ffrreq", 64'(ffrreq), 64'd0);
        check("midrst_flush_done", 64'(flush_done), 64'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        ordy = 1'b1;
        expect_beat(32'hE4E3E2E1, 4'hF);
        for (int i = 1; i <= 4; i++) push(8'(8'hE0 + i));
        drain_wait("postrst_drain");

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rshp_packer.md
RSHP_PACKER -- requirements
Module: rshp_packer

Interface
REQ-001 SHALL have parameter DW, default 8: FIFO word width in bits.
REQ-002 SHALL have parameter PK, default 4, legal range 2..16: FIFO words packed per output beat.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ffrempty, input, 1: upstream FIFO empty.
REQ-006 SHALL have port ffrreq, output, 1: upstream FIFO read request.
REQ-007 SHALL have port ffrdata, input, DW: FIFO read data, valid with ffrvld.
REQ-008 SHALL have port ffrvld, input, 1: FIFO read data valid, one cycle after ffrreq.
REQ-009 SHALL have port flush, input, 1: single-cycle request to emit any partial beat.
REQ-010 SHALL have port odata, output, PK*DW: packed beat; lane i = bits [i*DW +: DW].
REQ-011 SHALL have port okeep, output, PK: lane-valid mask for odata.
REQ-012 SHALL have port ovld, output, 1: output beat valid.
REQ-013 SHALL have port ordy, input, 1: downstream accepts the beat when ovld & ordy.
REQ-014 SHALL have port flush_done, output, 1: single-cycle pulse when a flush completes.

Function
REQ-015 SHALL track cnt, the filled lanes (0..PK), and inflight, which is ffrreq registered.
REQ-016 SHALL write each ffrvld word into lane cnt and increment cnt; lanes fill from 0 upward.
REQ-017 SHALL define oready as ~ovld | ordy.
REQ-018 SHALL drive ffrreq combinationally in state RUN: ~ffrempty & ((cnt+inflight < PK) | (cnt+inflight == PK & inflight & oready)).
REQ-019 SHALL, when ffrvld fills lane PK-1 and oready is high, load the completed beat into odata, set okeep to all ones and ovld to 1, and clear cnt to 0 on the same edge.
REQ-020 SHALL, when the beat completes and oready is low, hold the beat with cnt=PK and move it to the output on the first cycle oready is high.
REQ-021 SHALL hold ovld, odata and okeep stable while ovld & ~ordy.
REQ-022 SHALL clear ovld after ovld & ordy unless a new beat loads on the same edge.
REQ-023 SHALL sustain one FIFO word per cycle with ordy held high; latency from ffrvld of lane PK-1 to ovld is 1 cycle.
REQ-024 SHALL implement states RUN, DRAIN, EMIT and DONE.
REQ-025 SHALL go RUN->DRAIN on flush; ffrreq SHALL be 0 in every state except RUN.
REQ-026 SHALL leave DRAIN once inflight=0 and no full beat is pending: to EMIT if 0<cnt<PK, else to DONE.
REQ-027 SHALL, in EMIT, load the partial beat when oready is high: okeep bit i set for i<cnt, unused lanes zero, cnt cleared, then go to DONE.
REQ-028 SHALL, in DONE, pulse flush_done for exactly 1 cycle and return to RUN.
REQ-029 SHALL ignore flush asserted outside RUN.
REQ-030 SHALL let the pending ffrreq word land and count when flush coincides with ffrreq.
REQ-031 SHALL size cnt at $clog2(PK)+1 bits; cnt SHALL never exceed PK and there is no overflow or wrap.

Reset
REQ-032 SHALL, on reset assertion, force immediately: ffrreq=0, ovld=0, odata=0, okeep=0, flush_done=0, cnt=0, inflight=0, lanes=0, state=RUN.
REQ-033 SHALL discard any partial beat or in-flight FIFO read on reset mid-operation; the upstream FIFO SHALL be reset in the same domain.

Structure
REQ-034 SHALL take its state enum type (RUN/DRAIN/EMIT/DONE) and the default DW/PK constants from shared package rshp_pkg.
REQ-035 SHALL be a single module with no sub-modules; it connects to the reshaper FIFO ports of the same names.

Verification (DW=8, PK=4)
REQ-036 SHALL cover: FIFO holds 8 words 0x01..0x08, ordy=1 -> ffrreq high 8 consecutive cycles; beats 0x04030201 then 0x08070605 on consecutive-ready cycles, okeep=4'hF.
REQ-037 SHALL cover: same stimulus with ordy=0 for 10 cycles -> ffrreq stops after 8 words issued (first beat in output, second beat held at cnt=4); no word lost; ordy=1 yields both beats in order.
REQ-038 SHALL cover: 3 words 0xA1,0xA2,0xA3 then flush -> odata=0x00A3A2A1, okeep=4'b0111, then flush_done pulses 1 cycle after acceptance.
REQ-039 SHALL cover: flush with cnt=0 and inflight=0 -> no beat emitted; flush_done 2 cycles after flush (DRAIN, DONE).
REQ-040 SHALL cover: flush coincident with ffrreq on word 2 -> that word lands; beat okeep=4'b0011.
REQ-041 SHALL cover: reset pulsed with cnt=2 and ovld=1 -> all outputs 0 immediately; after release, 4 fresh words produce a clean full beat.
